// File: rtl/ctrl_reg_pkg.sv
// rtl/ctrl_reg_pkg.sv - shared FSM states, register-map offsets and router fields for ctrl_reg_bank
package ctrl_reg_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int OFS_OFFSET  = 0;
  localparam int OFS_DEST    = 1;
  localparam int OFS_NUMOPS  = 2;
  localparam int OFS_ROUTER  = 3;
  localparam int REGS_PER_CH = 4;

  localparam int RT_PARAM_NOT_LAYER  = 0;
  localparam int RT_WEIGHT_NOT_INDEX = 1;
  localparam int RT_CACHE_SEL_LSB    = 2;
  localparam int RT_CACHE_SEL_W      = 2;
  localparam int RT_ACT_FUNC_LSB     = 4;
  localparam int RT_ACT_FUNC_W       = 2;
  localparam int RT_WRITE_REVERSE    = 6;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ctrl_reg_bank_rr_arbiter.sv
// rtl/ctrl_reg_bank_rr_arbiter.sv - combinational round-robin arbiter, search starts after last_grant
module rr_arbiter
  import ctrl_reg_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_CH);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ctrl_reg_bank.sv
// rtl/ctrl_reg_bank.sv - multi-channel descriptor bank with round-robin dispatch to the layer FSM
// Define CTRL_REG_BANK_IRQ_EN to add the IEN register at STAT+1 and the registered irq output.
module ctrl_reg_bank
  import ctrl_reg_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h8000,
  parameter int                NUM_CH    = 2,
  parameter int                ROUTER_W  = 7
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      WE,
  input  logic [ADDR_W-1:0]         inAddr,
  input  logic [DATA_W-1:0]         inData,
  output logic [DATA_W-1:0]         outData,
  input  logic [DATA_W-1:0]         cacheDataOut,
  output logic [DATA_W-1:0]         cacheDataIn,
  output logic [ADDR_W-1:0]         cacheAddrIn,
  output logic                      cacheWE,
  input  logic                      beginOp,
  output logic                      fsmBeginOp,
  input  logic                      fsmReadyForNextOp,
  output logic                      readyForNextOp,
  output logic [idx_w(NUM_CH)-1:0]  activeCh,
  output logic [DATA_W-1:0]         offsetReg,
  output logic [DATA_W-1:0]         destReg,
  output logic [DATA_W-1:0]         numOpsReg,
  output logic [ROUTER_W-1:0]       routerReg
`ifdef CTRL_REG_BANK_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int IW       = idx_w(NUM_CH);
  localparam int FIELD_W  = $clog2(REGS_PER_CH);
  localparam int CTRL_OFS = REGS_PER_CH * NUM_CH;
  localparam int STAT_OFS = CTRL_OFS + 1;
`ifdef CTRL_REG_BANK_IRQ_EN
  localparam int IEN_OFS  = STAT_OFS + 1;
  localparam int LAST_OFS = IEN_OFS;
`else
  localparam int LAST_OFS = STAT_OFS;
`endif

  logic [DATA_W-1:0]   offset_q [NUM_CH];
  logic [DATA_W-1:0]   dest_q   [NUM_CH];
  logic [DATA_W-1:0]   numops_q [NUM_CH];
  logic [ROUTER_W-1:0] router_q [NUM_CH];

  logic [NUM_CH-1:0] pending_q, done_q;
  logic [IW-1:0]     active_q, last_q;
  state_t            state_q, state_d;

  logic              do_grant, set_done, busy;
  logic [NUM_CH-1:0] grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_valid;

  // Address decode: a borrow out of the subtraction means the address is below the window.
  logic [ADDR_W:0]        rel;
  logic [ADDR_W-1:0]      ofs;
  logic [IW-1:0]          sel_ch;
  logic [FIELD_W-1:0]     field;
  logic                   hit, is_ch, is_ctrl, is_stat;

  assign rel     = {1'b0, inAddr} - {1'b0, BASE_ADDR};
  assign ofs     = rel[ADDR_W-1:0];
  assign hit     = !rel[ADDR_W] && (ofs <= ADDR_W'(LAST_OFS));
  assign is_ch   = hit && (ofs < ADDR_W'(CTRL_OFS));
  assign is_ctrl = hit && (ofs == ADDR_W'(CTRL_OFS));
  assign is_stat = hit && (ofs == ADDR_W'(STAT_OFS));
  assign sel_ch  = ofs[FIELD_W +: IW];
  assign field   = ofs[FIELD_W-1:0];

  assign cacheDataIn = inData;
  assign cacheAddrIn = inAddr;
  assign cacheWE     = WE && !hit;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int c = 0; c < NUM_CH; c++) begin
        offset_q[c] <= '0;
        dest_q[c]   <= '0;
        numops_q[c] <= '0;
        router_q[c] <= '0;
      end
    end else if (WE && is_ch) begin
      case (field)
        FIELD_W'(OFS_OFFSET): offset_q[sel_ch] <= inData;
        FIELD_W'(OFS_DEST):   dest_q[sel_ch]   <= inData;
        FIELD_W'(OFS_NUMOPS): numops_q[sel_ch] <= inData;
        default:              router_q[sel_ch] <= inData[ROUTER_W-1:0];
      endcase
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IW)
  ) u_arb (
    .req         (pending_q),
    .last_grant  (last_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_valid && fsmReadyForNextOp) state_d = ISSUE;
      ISSUE:     state_d = WAIT_ACK;
      WAIT_ACK:  if (!fsmReadyForNextOp) state_d = WAIT_DONE;
      WAIT_DONE: if (fsmReadyForNextOp) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    do_grant   = (state_q == IDLE) && grant_valid && fsmReadyForNextOp;
    set_done   = (state_q == WAIT_DONE) && fsmReadyForNextOp;
    fsmBeginOp = (state_q == ISSUE);
    busy       = (state_q != IDLE);
  end

  // New requests are OR-ed in after the grant clear so a same-cycle re-request survives.
  logic [NUM_CH-1:0] req_set, w1c, done_set, grant_clr;

  assign req_set   = ((WE && is_ctrl) ? inData[NUM_CH-1:0] : '0) | NUM_CH'(beginOp);
  assign w1c       = (WE && is_stat) ? inData[NUM_CH:1] : '0;
  assign done_set  = set_done ? (NUM_CH'(1) << active_q) : '0;
  assign grant_clr = do_grant ? grant : '0;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pending_q <= '0;
      done_q    <= '0;
      active_q  <= '0;
      last_q    <= IW'(NUM_CH - 1);
      offsetReg <= '0;
      destReg   <= '0;
      numOpsReg <= '0;
      routerReg <= '0;
    end else begin
      pending_q <= (pending_q & ~grant_clr) | req_set;
      done_q    <= (done_q & ~w1c) | done_set;
      if (do_grant) begin
        active_q  <= grant_idx;
        last_q    <= grant_idx;
        offsetReg <= offset_q[grant_idx];
        destReg   <= dest_q[grant_idx];
        numOpsReg <= numops_q[grant_idx];
        routerReg <= router_q[grant_idx];
      end
    end
  end

  assign activeCh       = (NUM_CH == 1) ? '0 : active_q;
  assign readyForNextOp = (state_q == IDLE) && (pending_q == '0);

`ifdef CTRL_REG_BANK_IRQ_EN
  logic [NUM_CH-1:0] ien_q;
  logic              is_ien;

  assign is_ien = hit && (ofs == ADDR_W'(IEN_OFS));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ien_q <= '0;
      irq   <= 1'b0;
    end else begin
      if (WE && is_ien) ien_q <= inData[NUM_CH-1:0];
      irq <= |(done_q & ien_q);
    end
  end
`endif

  always_comb begin
    outData = cacheDataOut;
    if (is_ch) begin
      case (field)
        FIELD_W'(OFS_OFFSET): outData = offset_q[sel_ch];
        FIELD_W'(OFS_DEST):   outData = dest_q[sel_ch];
        FIELD_W'(OFS_NUMOPS): outData = numops_q[sel_ch];
        default:              outData = DATA_W'(router_q[sel_ch]);
      endcase
    end else if (is_ctrl) begin
      outData = DATA_W'(pending_q);
    end else if (is_stat) begin
      outData = DATA_W'({done_q, busy});
`ifdef CTRL_REG_BANK_IRQ_EN
    end else if (is_ien) begin
      outData = DATA_W'(ien_q);
`endif
    end
  end

endmodule

// File: tb/tb_ctrl_reg_bank.sv
// tb/tb_ctrl_reg_bank.sv - randomized self-checking bench for ctrl_reg_bank against a register-map model
`timescale 1ns/1ps
module tb_ctrl_reg_bank;

  localparam int          N    = 2;
  localparam logic [15:0] BASE = 16'h8000;
  localparam int          CTRL = 4 * N;
  localparam int          STAT = CTRL + 1;
`ifdef CTRL_REG_BANK_IRQ_EN
  localparam int          LAST = STAT + 1;
`else
  localparam int          LAST = STAT;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        WE;
  logic [15:0] inAddr, inData, outData, cacheDataOut, cacheDataIn, cacheAddrIn;
  logic        cacheWE, beginOp, fsmBeginOp, fsmReadyForNextOp, readyForNextOp;
  logic [0:0]  activeCh;
  logic [15:0] offsetReg, destReg, numOpsReg;
  logic [6:0]  routerReg;
`ifdef CTRL_REG_BANK_IRQ_EN
  logic        irq;
`endif

  ctrl_reg_bank #(
    .DATA_W(16), .ADDR_W(16), .BASE_ADDR(BASE), .NUM_CH(N), .ROUTER_W(7)
  ) dut (
    .clk(clk), .rstN(rstN), .WE(WE), .inAddr(inAddr), .inData(inData),
    .outData(outData), .cacheDataOut(cacheDataOut), .cacheDataIn(cacheDataIn),
    .cacheAddrIn(cacheAddrIn), .cacheWE(cacheWE), .beginOp(beginOp),
    .fsmBeginOp(fsmBeginOp), .fsmReadyForNextOp(fsmReadyForNextOp),
    .readyForNextOp(readyForNextOp), .activeCh(activeCh),
    .offsetReg(offsetReg), .destReg(destReg), .numOpsReg(numOpsReg),
    .routerReg(routerReg)
`ifdef CTRL_REG_BANK_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] m_off [N];
  logic [15:0] m_dst [N];
  logic [15:0] m_nop [N];
  logic [6:0]  m_rt  [N];
  logic [N-1:0] m_pend, m_done, m_ien;
  logic         m_busy;
  int           m_last;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    int off;
    logic [15:0] r;
    off = int'(a) - int'(BASE);
    r = cacheDataOut;
    if (off >= 0 && off < CTRL) begin
      case (off % 4)
        0: r = m_off[off / 4];
        1: r = m_dst[off / 4];
        2: r = m_nop[off / 4];
        default: r = 16'(m_rt[off / 4]);
      endcase
    end else if (off == CTRL) r = 16'(m_pend);
    else if (off == STAT) r = 16'({m_done, m_busy});
    else if (off >= 0 && off <= LAST) r = 16'(m_ien);
    return r;
  endfunction

  function automatic int pick();
    for (int i = 1; i <= N; i++)
      if (m_pend[(m_last + i) % N]) return (m_last + i) % N;
    return -1;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      m_off[c] = '0; m_dst[c] = '0; m_nop[c] = '0; m_rt[c] = '0;
    end
    m_pend = '0; m_done = '0; m_ien = '0; m_busy = 1'b0; m_last = N - 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    int off;
    inAddr = a; inData = d; WE = 1'b1;
    step();
    WE = 1'b0;
    off = int'(a) - int'(BASE);
    if (off >= 0 && off < CTRL) begin
      case (off % 4)
        0: m_off[off / 4] = d;
        1: m_dst[off / 4] = d;
        2: m_nop[off / 4] = d;
        default: m_rt[off / 4] = d[6:0];
      endcase
    end else if (off == CTRL) m_pend = m_pend | d[N-1:0];
    else if (off == STAT) m_done = m_done & ~d[N:1];
    else if (off >= 0 && off <= LAST) m_ien = d[N-1:0];
  endtask

  task automatic rd(input string tag, input logic [15:0] a);
    inAddr = a; WE = 1'b0;
    #1;
    check_eq(tag, outData, exp_read(a));
  endtask

  task automatic program_random();
    for (int c = 0; c < N; c++)
      for (int f = 0; f < 4; f++)
        bus_wr(BASE + 16'(4 * c + f), 16'($urandom));
  endtask

  // Runs one operation through a scripted FSM handshake; optional same-cycle disturbances.
  task automatic serve(input bit mod_active, input bit w1c_hit, output int lat);
    int w;
    logic [15:0] snap;
    w = pick();
    lat = 0;
    while (fsmBeginOp !== 1'b1 && lat < 8) begin
      step();
      lat++;
    end
    check_eq("begin_seen", fsmBeginOp, 1);
    check_eq("active_ch", activeCh, w);
    check_eq("snap_offset", offsetReg, m_off[w]);
    check_eq("snap_dest", destReg, m_dst[w]);
    check_eq("snap_numops", numOpsReg, m_nop[w]);
    check_eq("snap_router", routerReg, m_rt[w]);
    snap = m_off[w];
    m_pend[w] = 1'b0; m_last = w; m_busy = 1'b1;
    step();
    check_eq("begin_one_cycle", fsmBeginOp, 0);
    fsmReadyForNextOp = 1'b0;
    step();
    step();
    rd("stat_busy", BASE + 16'(STAT));
    if (mod_active) begin
      bus_wr(BASE + 16'(4 * w), 16'($urandom));
      check_eq("snap_hold", offsetReg, snap);
      rd("reg_after_active_wr", BASE + 16'(4 * w));
    end
    fsmReadyForNextOp = 1'b1;
    if (w1c_hit) bus_wr(BASE + 16'(STAT), 16'(1) << (w + 1));
    else step();
    m_done[w] = 1'b1; m_busy = 1'b0;
    rd("stat_done", BASE + 16'(STAT));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, n;
    logic [15:0] a;
    rstN = 1'b1; WE = 1'b0; inAddr = '0; inData = '0; beginOp = 1'b0;
    fsmReadyForNextOp = 1'b1; cacheDataOut = 16'hBEEF;
    model_clear();
    #1 rstN = 1'b0;
    #2;
    check_eq("rst_begin", fsmBeginOp, 0);
    check_eq("rst_active", activeCh, 0);
    check_eq("rst_offset", offsetReg, 0);
    check_eq("rst_router", routerReg, 0);
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;
    step();
    check_eq("rst_ready", readyForNextOp, 1);

    for (int i = 0; i <= 9; i++) begin
      rd("reset_readback", BASE + 16'(i));
      step();
    end
    rd("cache_passthru", 16'h0010);
    inData = 16'h5A5A; #1;
    check_eq("cache_addr_in", cacheAddrIn, 16'h0010);
    check_eq("cache_data_in", cacheDataIn, 16'h5A5A);
    inAddr = BASE; WE = 1'b1; #1;
    check_eq("cache_we_window", cacheWE, 0);
    WE = 1'b0;
    step();

    bus_wr(16'h8004, 16'h1234);
    rd("ch1_offset_rw", 16'h8004);
    bus_wr(16'h8003, 16'hFFFF);
    rd("router_zero_ext", 16'h8003);

    for (int i = 0; i < 40; i++) begin
      cacheDataOut = 16'($urandom);
      case ($urandom_range(0, 2))
        0: a = 16'($urandom_range(0, 16'h7FFF));
        1: a = BASE + 16'(LAST + 1) + 16'($urandom_range(0, 64));
        default: a = BASE + 16'($urandom_range(0, CTRL - 1));
      endcase
      inAddr = a; inData = 16'($urandom); WE = 1'b1; #1;
      check_eq("cache_we_rand", cacheWE, (a < BASE || a > BASE + 16'(LAST)));
      WE = 1'b0;
      bus_wr(a, inData);
      a = (i % 3 == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, LAST + 2));
      rd("rand_read", a);
    end

    bus_wr(BASE + 16'(CTRL), 16'h0001);
    serve(1'b0, 1'b0, lat);
    check_eq("dispatch_latency", lat, 1);
    check_eq("ready_after_op", readyForNextOp, 1);
    check_eq("stat_ch0_done", outData, 16'h0002);
    bus_wr(BASE + 16'(STAT), 16'h0002);
    rd("stat_w1c", BASE + 16'(STAT));

    rstN = 1'b0; model_clear(); @(negedge clk); rstN = 1'b1; step();
    program_random();
    for (int r = 0; r < 2; r++) begin
      bus_wr(BASE + 16'(CTRL), 16'h0003);
      serve(1'b0, 1'b0, lat);
      check_eq("rr_first_ch0", activeCh, 0);
      serve(1'b0, 1'b0, lat);
      check_eq("rr_second_ch1", activeCh, 1);
    end

    bus_wr(BASE + 16'(CTRL), 16'h0001);
    bus_wr(BASE + 16'(CTRL), 16'h0001);
    serve(1'b0, 1'b0, lat);
    m_pend[0] = 1'b1;
    rd("requeue_pending", BASE + 16'(CTRL));
    check_eq("requeue_not_ready", readyForNextOp, 0);
    serve(1'b0, 1'b0, lat);

    beginOp = 1'b1; step(); beginOp = 1'b0;
    m_pend[0] = 1'b1;
    serve(1'b0, 1'b0, lat);

    bus_wr(BASE + 16'(CTRL), 16'h0002);
    serve(1'b1, 1'b1, lat);

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) program_random();
      bus_wr(BASE + 16'(CTRL), 16'($urandom_range(1, 3)));
      n = 0;
      while (m_pend != '0 && n < 4) begin
        serve(1'($urandom), 1'($urandom), lat);
        n++;
      end
      check_eq("rand_drain_ready", readyForNextOp, 1);
      bus_wr(BASE + 16'(STAT), 16'($urandom));
      rd("rand_stat", BASE + 16'(STAT));
    end

`ifdef CTRL_REG_BANK_IRQ_EN
    bus_wr(BASE + 16'(STAT), 16'hFFFF);
    bus_wr(BASE + 16'(LAST), 16'h0001);
    rd("ien_readback", BASE + 16'(LAST));
    bus_wr(BASE + 16'(CTRL), 16'h0001);
    serve(1'b0, 1'b0, lat);
    check_eq("irq_not_yet", irq, 0);
    step();
    check_eq("irq_set", irq, 1);
    bus_wr(BASE + 16'(STAT), 16'h0002);
    step();
    check_eq("irq_cleared", irq, 0);
`endif

    bus_wr(BASE + 16'(CTRL), 16'h0001);
    n = 0;
    while (fsmBeginOp !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check_eq("abort_begin_seen", fsmBeginOp, 1);
    fsmReadyForNextOp = 1'b0;
    step(); step();
    #2 rstN = 1'b0;
    model_clear();
    #1;
    check_eq("abort_begin", fsmBeginOp, 0);
    check_eq("abort_offset", offsetReg, 0);
    check_eq("abort_dest", destReg, 0);
    check_eq("abort_numops", numOpsReg, 0);
    check_eq("abort_router", routerReg, 0);
    check_eq("abort_active", activeCh, 0);
    rd("abort_pending", BASE + 16'(CTRL));
    rd("abort_stat", BASE + 16'(STAT));
    fsmReadyForNextOp = 1'b1;
    @(negedge clk); rstN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("post_abort_idle", {fsmBeginOp, readyForNextOp}, 2'b01);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
